pio_ram_read_port: RTL and testbench
====================================

Name: pio_ram_read_port

Overview:
- Host-side serial memory read port inside julia_top; sits directly upstream of the PIO RAM emulator link.
- Accepts one read request at a time from core logic and serialises the address onto the 2-bit tx_pins.
- Deserialises the reply arriving on the 2-bit rx_pins and returns the data word, or an error, to the core.
- tx_pins and rx_pins are both registered inside this block, as the link latency budget requires.

Parameters:
- ADDR_BITS, 16, read address width; must be even; address beats = ADDR_BITS/2.
- DATA_BITS, 16, reply data width; must be even; data beats = DATA_BITS/2.
- TIMEOUT, 63, maximum WAIT cycles without a reply start before an error response is returned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_BITS  read address; sampled when req_valid && req_ready.
- resp_valid  out  1  single-cycle pulse; resp_data and resp_error are valid in that cycle.
- resp_data  out  DATA_BITS  read data; 0 when resp_error=1.
- resp_error  out  1  set for an error reply or a timeout.
- tx_pins  out  2  serial link to the emulator; registered; idle level 2'b11.
- rx_pins  in  2  serial link from the emulator; registered on entry (rx_q).

Behaviour:
Clock, reset and link format:
- One clock domain: clk. Reset is synchronous, active-low (rst_n).
- Reset values: state=IDLE, tx_pins=2'b11, rx_q=2'b11, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, all counters 0.
- Link symbol format, both directions: idle is 2'b11.
- Start cycle: pin0=0 and pin1=type bit. Requests use type 0 (read). Replies use type 0 (data) or type 1 (error).
- Start cycle is followed by payload beats of 2 bits each, LSB first; bit[2k] on pin0 and bit[2k+1] on pin1 in beat k.

State machine:
- IDLE: req_ready=1. On accept in cycle N: latch req_addr, go to SEND. tx_pins=2'b10 (start, type 0) at edge N+1.
- SEND: drives ADDR_BITS/2 address beats on edges N+2 to N+1+ADDR_BITS/2. After the last beat, tx_pins=2'b11 and go to WAIT with the timeout counter cleared.
- WAIT: the receiver is armed only in this state.
  - If rx_q[0]==0: latch rx_q[1] as the error flag, clear the beat counter, go to RECV.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, pulse resp_valid with resp_error=1 and resp_data=0, then go to IDLE.
- RECV: shifts in DATA_BITS/2 beats from rx_q. In the cycle after the last beat is captured, pulse resp_valid; resp_error = latched flag; resp_data = assembled word, or 0 if the flag is set. Go to IDLE.
- Beats in RECV are positional: no start detection happens there, and pin values are taken as data even if they read 2'b11.

Timing and boundaries:
- Latency from request accept to resp_valid = 1 + 1 + ADDR_BITS/2 + emulator latency + 1 (rx register) + DATA_BITS/2 + 1. The bench measures this; it must match to the cycle.
- Back-to-back requests: req_ready rises in the cycle after the resp_valid pulse. A request can be accepted in that same cycle, so the next start symbol appears 2 edges after resp_valid.
- rx activity outside WAIT is ignored and never produces resp_valid.
- req_valid while req_ready=0 is ignored; no queueing.
- A start arriving in the same cycle the timeout fires: the timeout wins, and the late reply is ignored because the block is no longer in WAIT.
- Reset mid-operation:
  - Next edge returns to IDLE with tx_pins=2'b11, regardless of state.
  - A partially sent request is abandoned; no resp_valid is emitted for it.
  - Stray reply beats from the abandoned request are ignored unless they arrive after a new request has reached WAIT.

Test Plan:
1. Single read: addr=16'h1234, emulator returns 16'hBEEF after latency 22. tx_pins sequence is 10,00,01,11,00,10,00,01,00 (start, then beats LSB first), then 11. One resp_valid with data=16'hBEEF, error=0, at the computed cycle.
2. Error reply: emulator answers with a type-1 start. resp_valid with resp_error=1 and resp_data=0. Next request proceeds normally.
3. Timeout: rx_pins held at 2'b11. Exactly TIMEOUT WAIT cycles later, resp_valid=1 with error=1. req_ready is high in the following cycle.
4. Back-to-back: 4 reads at addresses 0, 1, 16'hFFFF, 16'h8000 with req_valid held high. Exactly 4 responses, in order, each with the correct data. Next start symbol appears 2 edges after each resp_valid.
5. Reset mid-SEND: rst_n=0 for 1 cycle after the 3rd address beat. tx_pins=2'b11 and req_ready=1 after the edge. No resp_valid is emitted. A fresh read then completes correctly.
6. Spurious rx: toggle rx_pins to 2'b00 and 2'b01 while in IDLE. No resp_valid, and state stays IDLE.

Source files
------------

// File: rtl/pio_ram_read_port.sv
// Host-side serial memory read port: sends a read address over the 2-bit tx
// link and returns the data/error reply deserialised from the 2-bit rx link.
module pio_ram_read_port #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 resp_error,
  output logic [1:0]           tx_pins,
  input  logic [1:0]           rx_pins
);

  localparam int unsigned ADDR_BEATS = ADDR_BITS / 2;
  localparam int unsigned DATA_BEATS = DATA_BITS / 2;
  localparam int unsigned MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int unsigned BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BEAT_W-1:0] ADDR_LAST = BEAT_W'(ADDR_BEATS - 1);
  localparam logic [BEAT_W-1:0] DATA_LAST = BEAT_W'(DATA_BEATS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  // S_DONE holds the response pulse so req_ready rises one cycle after it
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             rx_q;
  logic [ADDR_BITS-1:0]   addr_sr;
  logic [DATA_BITS-1:0]   data_sr;
  logic [DATA_BITS-1:0]   data_shift;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic                   err_q;

  logic [1:0]             tx_nxt;
  logic                   ready_nxt;
  logic                   valid_nxt;
  logic [DATA_BITS-1:0]   data_nxt;
  logic                   err_nxt;

  // Reply beats arrive LSB first, so each new beat enters at the top
  assign data_shift = (data_sr >> 2) | (DATA_BITS'(rx_q) << (DATA_BITS - 2));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a timeout in WAIT takes priority over a start seen that cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_valid && req_ready) state_nxt = S_SEND;
      S_SEND:  if (beat_cnt == ADDR_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (to_cnt == TO_LAST)  state_nxt = S_DONE;
        else if (!rx_q[0])      state_nxt = S_RECV;
      end
      S_RECV:  if (beat_cnt == DATA_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    tx_nxt    = 2'b11;
    ready_nxt = (state_nxt == S_IDLE);
    valid_nxt = (state_nxt == S_DONE);
    data_nxt  = resp_data;
    err_nxt   = resp_error;
    unique case (state)
      S_IDLE: if (state_nxt == S_SEND) tx_nxt = 2'b10;
      S_SEND: tx_nxt = addr_sr[1:0];
      S_WAIT: begin
        if (state_nxt == S_DONE) begin
          data_nxt = '0;
          err_nxt  = 1'b1;
        end
      end
      S_RECV: begin
        if (state_nxt == S_DONE) begin
          err_nxt  = err_q;
          data_nxt = err_q ? '0 : data_shift;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q       <= 2'b11;
      tx_pins    <= 2'b11;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      addr_sr    <= '0;
      data_sr    <= '0;
      beat_cnt   <= '0;
      to_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      rx_q       <= rx_pins;
      tx_pins    <= tx_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= valid_nxt;
      resp_data  <= data_nxt;
      resp_error <= err_nxt;
      unique case (state)
        S_IDLE: begin
          if (state_nxt == S_SEND) begin
            addr_sr  <= req_addr;
            beat_cnt <= '0;
          end
        end
        S_SEND: begin
          addr_sr  <= addr_sr >> 2;
          beat_cnt <= beat_cnt + BEAT_W'(1);
          to_cnt   <= '0;
        end
        S_WAIT: begin
          if (state_nxt == S_RECV) begin
            err_q    <= rx_q[1];
            beat_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_RECV: begin
          data_sr  <= data_shift;
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_ram_read_port.sv
// Bench for pio_ram_read_port: behavioural link emulator plus memory model,
// directed scenarios with randomized addresses, data and reply latencies.
module tb_pio_ram_read_port;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int TO  = 63;
  localparam int LOG = 8192;

  typedef struct {
    int          e;
    logic [15:0] data;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_error;
  logic [1:0]  tx_pins;
  logic [1:0]  rx_pins;

  logic        spur_en;
  logic [1:0]  spur_val;
  logic [1:0]  emu_rx = 2'b11;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  logic [1:0]  tx_log  [LOG];
  logic        rdy_log [LOG];
  int          acc_q   [$];
  resp_t       resp_q  [$];
  logic [15:0] mem     [int];

  int          emu_mode;
  int          emu_lat;
  int          emu_ph   = 0;
  int          emu_cnt  = 0;
  int          emu_dly  = 0;
  logic [15:0] emu_sr   = '0;
  logic [15:0] emu_word = '0;
  logic        emu_type = 1'b0;

  assign rx_pins = spur_en ? spur_val : emu_rx;

  pio_ram_read_port #(
    .ADDR_BITS(16),
    .DATA_BITS(16),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_error(resp_error),
    .tx_pins   (tx_pins),
    .rx_pins   (rx_pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #80000;
    $display("FAIL watchdog: time bound expired before the summary");
    $fatal(1, "watchdog");
  end

  // Edge E sees the values set by edge E-1; log them under that edge number
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 0 && cyc <= LOG) begin
      tx_log[cyc-1]  <= tx_pins;
      rdy_log[cyc-1] <= req_ready;
    end
    if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    if (resp_valid) resp_q.push_back(resp_t'{cyc - 1, resp_data, resp_error});
  end

  // Emulator: decodes a request frame, then after emu_lat edges answers with
  // a start symbol and DB payload beats (mode 0 data, 1 error, 2 silent)
  always @(posedge clk) begin
    if (!rst_n) begin
      emu_ph <= 0;
      emu_rx <= 2'b11;
    end else begin
      case (emu_ph)
        0: if (tx_pins == 2'b10) begin
          emu_ph  <= 1;
          emu_cnt <= 0;
        end
        1: begin
          emu_sr  <= {tx_pins, emu_sr[15:2]};
          emu_cnt <= emu_cnt + 1;
          if (emu_cnt == AB - 1) begin
            if (emu_mode == 2) emu_ph <= 0;
            else begin
              emu_ph   <= 2;
              emu_dly  <= emu_lat;
              emu_type <= (emu_mode == 1);
              emu_word <= (emu_mode == 1) ? 16'($urandom) : mem[int'({tx_pins, emu_sr[15:2]})];
            end
          end
        end
        2: if (emu_dly == 1) begin
          emu_rx  <= {emu_type, 1'b0};
          emu_ph  <= 3;
          emu_cnt <= 0;
        end else emu_dly <= emu_dly - 1;
        3: if (emu_cnt < DB) begin
          emu_rx  <= emu_word[2*emu_cnt +: 2];
          emu_cnt <= emu_cnt + 1;
        end else begin
          emu_rx <= 2'b11;
          emu_ph <= 0;
        end
        default: emu_ph <= 0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [15:0] a, output int a_edge);
    int n0;
    int t;
    n0 = acc_q.size();
    t = 0;
    req_addr  = a;
    req_valid = 1'b1;
    while (acc_q.size() == n0 && t < 200) begin
      tick(1);
      t++;
    end
    req_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(acc_q.size() > n0), 32'd1);
    a_edge = (acc_q.size() > n0) ? acc_q[n0] : -1000;
  endtask

  // One read through the emulator; checks reply, latency and the tx frame
  task automatic read_chk(input string tag, input logic [15:0] a, input int mode,
                          input int lat, input bit exp_to, output int r_edge);
    int          a_edge;
    int          n0;
    int          t;
    resp_t       r;
    logic        exp_e;
    logic [15:0] exp_d;
    logic [1:0]  exp_tx;
    if (!mem.exists(int'(a))) mem[int'(a)] = 16'($urandom);
    emu_mode = mode;
    emu_lat  = lat;
    n0 = resp_q.size();
    issue(tag, a, a_edge);
    t = 0;
    while (resp_q.size() == n0 && t < 400) begin
      tick(1);
      t++;
    end
    chk({tag, "_resp_seen"}, 32'(resp_q.size() > n0), 32'd1);
    if (resp_q.size() == n0) begin
      r_edge = -1000;
      return;
    end
    r = resp_q[n0];
    exp_e = exp_to || (mode == 1);
    exp_d = exp_e ? 16'h0000 : mem[int'(a)];
    chk({tag, "_data"}, 32'(r.data), 32'(exp_d));
    chk({tag, "_error"}, 32'(r.err), 32'(exp_e));
    if (exp_to) chk({tag, "_wait_cycles"}, r.e - (a_edge + AB), TO);
    else chk({tag, "_latency"}, r.e - a_edge + 1, 1 + 1 + AB + lat + 1 + DB + 1);
    tick(DB + 4);
    for (int k = 0; k <= AB + 1; k++) begin
      if (k == 0) exp_tx = 2'b10;
      else if (k == AB + 1) exp_tx = 2'b11;
      else exp_tx = 2'((a >> (2 * (k - 1))) & 16'h3);
      chk($sformatf("%s_tx%0d", tag, k), 32'(tx_log[a_edge + k]), 32'(exp_tx));
    end
    r_edge = r.e;
  endtask

  initial begin
    int          r_edge;
    int          a_edge;
    int          n0;
    int          na0;
    int          t;
    int          lat;
    int          mode;
    resp_t       r;
    logic [15:0] a;
    logic [15:0] addrs [4];

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    spur_en = 1'b0; spur_val = 2'b11; emu_mode = 0; emu_lat = 22;
    tick(3);
    chk("reset_tx", 32'(tx_pins), 32'h3);
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_valid", 32'(resp_valid), 32'h0);
    chk("reset_data", 32'(resp_data), 32'h0);
    chk("reset_error", 32'(resp_error), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Single read from the worked example
    mem[int'(16'h1234)] = 16'hBEEF;
    read_chk("t1", 16'h1234, 0, 22, 1'b0, r_edge);

    // Error reply, then a normal read
    read_chk("t2_err", 16'($urandom), 1, $urandom_range(1, 40), 1'b0, r_edge);
    read_chk("t2_next", 16'($urandom), 0, $urandom_range(1, 40), 1'b0, r_edge);

    // Silent emulator: timeout, then req_ready in the following cycle
    read_chk("t3_to", 16'($urandom), 2, 1, 1'b1, r_edge);
    chk("t3_ready_in_pulse", 32'(rdy_log[r_edge]), 32'h0);
    chk("t3_ready_after", 32'(rdy_log[r_edge + 1]), 32'h1);

    // Start lands exactly when the timeout fires: timeout wins
    n0 = resp_q.size();
    read_chk("t3_late", 16'($urandom), 0, TO - 3, 1'b1, r_edge);
    tick(40);
    chk("t3_late_single_resp", resp_q.size() - n0, 1);
    // One cycle earlier the start wins
    read_chk("t3_edge", 16'($urandom), 0, TO - 4, 1'b0, r_edge);

    // Back-to-back reads with req_valid held high
    addrs[0] = 16'h0000; addrs[1] = 16'h0001; addrs[2] = 16'hFFFF; addrs[3] = 16'h8000;
    for (int i = 0; i < 4; i++) if (!mem.exists(int'(addrs[i]))) mem[int'(addrs[i])] = 16'($urandom);
    emu_mode = 0;
    emu_lat  = $urandom_range(1, 30);
    na0 = acc_q.size();
    n0  = resp_q.size();
    req_addr  = addrs[0];
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (acc_q.size() <= na0 + i && t < 300) begin
        tick(1);
        t++;
      end
      if (i < 3) req_addr = addrs[i + 1];
      else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    t = 0;
    while (resp_q.size() < n0 + 4 && t < 300) begin
      tick(1);
      t++;
    end
    tick(40);
    chk("t4_resp_count", resp_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      r = resp_q[n0 + i];
      chk($sformatf("t4_data%0d", i), 32'(r.data), 32'(mem[int'(addrs[i])]));
      chk($sformatf("t4_error%0d", i), 32'(r.err), 32'h0);
      if (i < 3) begin
        chk($sformatf("t4_next_accept%0d", i), acc_q[na0 + i + 1], r.e + 2);
        chk($sformatf("t4_next_start%0d", i), 32'(tx_log[r.e + 2]), 32'h2);
      end
    end

    // Reset after the third address beat abandons the request
    a = 16'($urandom);
    emu_mode = 0;
    emu_lat  = 5;
    if (!mem.exists(int'(a))) mem[int'(a)] = 16'($urandom);
    n0 = resp_q.size();
    issue("t5", a, a_edge);
    tick(3);
    chk("t5_third_beat", 32'(tx_pins), 32'((a >> 4) & 16'h3));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_tx_idle", 32'(tx_pins), 32'h3);
    chk("t5_ready", 32'(req_ready), 32'h1);
    tick(TO + 30);
    chk("t5_no_resp", resp_q.size() - n0, 0);
    read_chk("t5_fresh", 16'($urandom), 0, $urandom_range(1, 40), 1'b0, r_edge);

    // Randomized reads
    for (int i = 0; i < 4; i++) begin
      mode = $urandom_range(0, 1);
      lat  = $urandom_range(1, 50);
      read_chk($sformatf("rnd%0d", i), 16'($urandom), mode, lat, 1'b0, r_edge);
    end

    // Spurious rx activity in IDLE
    n0 = resp_q.size();
    spur_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spur_val = (i % 2 == 0) ? 2'b00 : 2'b01;
      tick(1);
      chk($sformatf("t6_ready%0d", i), 32'(req_ready), 32'h1);
    end
    spur_en = 1'b0;
    tick(20);
    chk("t6_no_resp", resp_q.size() - n0, 0);
    chk("t6_tx_idle", 32'(tx_pins), 32'h3);
    chk("t6_ready_end", 32'(req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
